// File: rtl/ex_stage_pkg.sv
// Shared types and constants for the MIPS execute stage: bus layouts,
// stall-vector bit positions, one-hot ALU/select encodings and divider states.
package ex_stage_pkg;
   localparam int   STALL_WD     = 6;
   localparam int   STALL_ID_EX  = 2;
   localparam int   STALL_EX_MEM = 3;
   localparam logic STOP         = 1'b1;
   localparam logic NO_STOP      = 1'b0;

   // md_op = {div, divu, mfhi, mflo}
   localparam int MD_DIV  = 3;
   localparam int MD_DIVU = 2;
   localparam int MD_MFHI = 1;
   localparam int MD_MFLO = 0;

   localparam int OP_ADD = 11, OP_SUB = 10, OP_SLT = 9, OP_SLTU = 8;
   localparam int OP_AND = 7,  OP_NOR = 6,  OP_OR  = 5, OP_XOR  = 4;
   localparam int OP_SLL = 3,  OP_SRL = 2,  OP_SRA = 1, OP_LUI  = 0;

   localparam int SRC1_RS = 0, SRC1_PC = 1, SRC1_SA = 2;
   localparam int SRC2_RT = 0, SRC2_SIMM = 1, SRC2_8 = 2, SRC2_ZIMM = 3;

   typedef enum logic [1:0] {
      DIV_IDLE = 2'd0,
      DIV_RUN  = 2'd1,
      DIV_DONE = 2'd2
   } div_state_e;

   // sa is imm[10:6], so the immediate field carries both
   typedef struct packed {
      logic [3:0]  md_op;
      logic [3:0]  mem_op;
      logic [31:0] pc;
      logic [15:0] imm;
      logic [11:0] alu_op;
      logic [2:0]  sel_alu_src1;
      logic [3:0]  sel_alu_src2;
      logic        data_ram_en;
      logic [3:0]  data_ram_wen;
      logic        rf_we;
      logic [4:0]  rf_waddr;
      logic        sel_rf_res;
      logic [31:0] rdata1;
      logic [31:0] rdata2;
   } id_to_ex_t;

   localparam int ID_TO_EX_WD  = $bits(id_to_ex_t);
   localparam int EX_TO_MEM_WD = 80;
   localparam int EX_TO_RF_WD  = 38;
endpackage

// File: rtl/alu.sv
// Combinational MIPS ALU driven by a 12-bit one-hot operation select.
module alu
   import ex_stage_pkg::*;
(
   input  logic [11:0] alu_control,
   input  logic [31:0] alu_src1,
   input  logic [31:0] alu_src2,
   output logic [31:0] alu_result
);
   logic [31:0] add_res, sub_res, sra_res;
   logic        slt_res, sltu_res;

   assign add_res  = alu_src1 + alu_src2;
   assign sub_res  = alu_src1 - alu_src2;
   assign sra_res  = $signed(alu_src2) >>> alu_src1[4:0];
   assign slt_res  = $signed(alu_src1) < $signed(alu_src2);
   assign sltu_res = alu_src1 < alu_src2;

   // shifts take the amount from src1 and the value from src2
   assign alu_result = ({32{alu_control[OP_ADD]}}  & add_res)
                     | ({32{alu_control[OP_SUB]}}  & sub_res)
                     | ({32{alu_control[OP_SLT]}}  & {31'd0, slt_res})
                     | ({32{alu_control[OP_SLTU]}} & {31'd0, sltu_res})
                     | ({32{alu_control[OP_AND]}}  & (alu_src1 & alu_src2))
                     | ({32{alu_control[OP_NOR]}}  & ~(alu_src1 | alu_src2))
                     | ({32{alu_control[OP_OR]}}   & (alu_src1 | alu_src2))
                     | ({32{alu_control[OP_XOR]}}  & (alu_src1 ^ alu_src2))
                     | ({32{alu_control[OP_SLL]}}  & (alu_src2 << alu_src1[4:0]))
                     | ({32{alu_control[OP_SRL]}}  & (alu_src2 >> alu_src1[4:0]))
                     | ({32{alu_control[OP_SRA]}}  & sra_res)
                     | ({32{alu_control[OP_LUI]}}  & {alu_src2[15:0], 16'd0});
endmodule

// File: rtl/ex_stage_div.sv
// Iterative restoring divider: magnitudes in, one quotient bit per cycle,
// sign fix-up on the way out. Divide by zero yields all-ones and the dividend.
module div_iter
   import ex_stage_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         signed_op,
   input  logic [W-1:0] opa,
   input  logic [W-1:0] opb,
   input  logic         ack,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient,
   output logic [W-1:0] remainder
);
   localparam int CW = $clog2(W);

   div_state_e   state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic         negq_q, negq_d, negr_q, negr_d, zero_q, zero_d;
   logic [W:0]   shifted, trial;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= DIV_IDLE;
         cnt_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         dvs_q   <= '0;
         negq_q  <= 1'b0;
         negr_q  <= 1'b0;
         zero_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         dvs_q   <= dvs_d;
         negq_q  <= negq_d;
         negr_q  <= negr_d;
         zero_q  <= zero_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         DIV_IDLE: if (start) state_d = DIV_RUN;
         DIV_RUN:  if (cnt_q == CW'(W - 1)) state_d = DIV_DONE;
         DIV_DONE: if (ack) state_d = DIV_IDLE;
         default:  state_d = DIV_IDLE;
      endcase
   end

   assign shifted = {rem_q, quo_q[W-1]};
   assign trial   = shifted - {1'b0, dvs_q};

   always_comb begin
      cnt_d  = cnt_q;
      rem_d  = rem_q;
      quo_d  = quo_q;
      dvs_d  = dvs_q;
      negq_d = negq_q;
      negr_d = negr_q;
      zero_d = zero_q;
      if (state_q == DIV_IDLE && start) begin
         cnt_d  = '0;
         rem_d  = '0;
         quo_d  = (signed_op && opa[W-1]) ? -opa : opa;
         dvs_d  = (signed_op && opb[W-1]) ? -opb : opb;
         negq_d = signed_op & (opa[W-1] ^ opb[W-1]);
         negr_d = signed_op & opa[W-1];
         zero_d = (opb == '0);
      end else if (state_q == DIV_RUN) begin
         cnt_d = cnt_q + 1'b1;
         if (!trial[W]) begin
            rem_d = trial[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b1};
         end else begin
            rem_d = shifted[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
         end
      end
   end

   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         DIV_IDLE: busy = start;
         DIV_RUN:  busy = 1'b1;
         DIV_DONE: done = 1'b1;
         default:  ;
      endcase
   end

   // with a zero divisor the restored remainder is |dividend|, so the sign fix gives the dividend back
   assign quotient  = (negq_q && !zero_q) ? -quo_q : quo_q;
   assign remainder = negr_q ? -rem_q : rem_q;
endmodule

// File: rtl/ex_stage.sv
// MIPS execute stage: ID/EX register, ALU operand selection, data SRAM request,
// forwarding bus, HI/LO registers and the stall handshake for the divider.
module ex_stage
   import ex_stage_pkg::*;
#(
   parameter int DIV_BITS = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [STALL_WD-1:0]     stall,
   input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
   output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
   output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
   output logic                    data_sram_en,
   output logic [3:0]              data_sram_wen,
   output logic [31:0]             data_sram_addr,
   output logic [31:0]             data_sram_wdata,
   output logic                    stallreq_for_ex
);
   id_to_ex_t   id_ex_q, id_ex_d;
   logic [31:0] hi_q, hi_d, lo_q, lo_d;
   logic [31:0] alu_src1, alu_src2, alu_result, ex_result;
   logic [31:0] imm_sext, imm_zext, sa_zext;
   logic        div_done, div_ack;
   logic [31:0] div_quo, div_rem;
   logic        stall_unused;

   // only the ID/EX and EX/MEM stall bits matter here
   assign stall_unused = ^{stall[5:4], stall[1:0]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         id_ex_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         id_ex_q <= id_ex_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_comb begin
      id_ex_d = id_ex_q;
      if (stall[STALL_ID_EX] == STOP && stall[STALL_EX_MEM] == NO_STOP)
         id_ex_d = '0;
      else if (stall[STALL_ID_EX] == NO_STOP)
         id_ex_d = id_to_ex_t'(id_to_ex_bus);
   end

   assign imm_sext = {{16{id_ex_q.imm[15]}}, id_ex_q.imm};
   assign imm_zext = {16'd0, id_ex_q.imm};
   assign sa_zext  = {27'd0, id_ex_q.imm[10:6]};

   assign alu_src1 = ({32{id_ex_q.sel_alu_src1[SRC1_RS]}}   & id_ex_q.rdata1)
                   | ({32{id_ex_q.sel_alu_src1[SRC1_PC]}}   & id_ex_q.pc)
                   | ({32{id_ex_q.sel_alu_src1[SRC1_SA]}}   & sa_zext);
   assign alu_src2 = ({32{id_ex_q.sel_alu_src2[SRC2_RT]}}   & id_ex_q.rdata2)
                   | ({32{id_ex_q.sel_alu_src2[SRC2_SIMM]}} & imm_sext)
                   | ({32{id_ex_q.sel_alu_src2[SRC2_8]}}    & 32'd8)
                   | ({32{id_ex_q.sel_alu_src2[SRC2_ZIMM]}} & imm_zext);

   alu u_alu (
      .alu_control (id_ex_q.alu_op),
      .alu_src1    (alu_src1),
      .alu_src2    (alu_src2),
      .alu_result  (alu_result)
   );

   // the result is retired only when EX/MEM can accept the instruction
   assign div_ack = (stall[STALL_EX_MEM] == NO_STOP);

   div_iter #(.W(DIV_BITS)) u_div (
      .clk       (clk),
      .rst       (rst),
      .start     (id_ex_q.md_op[MD_DIV] | id_ex_q.md_op[MD_DIVU]),
      .signed_op (id_ex_q.md_op[MD_DIV]),
      .opa       (id_ex_q.rdata1),
      .opb       (id_ex_q.rdata2),
      .ack       (div_ack),
      .busy      (stallreq_for_ex),
      .done      (div_done),
      .quotient  (div_quo),
      .remainder (div_rem)
   );

   always_comb begin
      hi_d = hi_q;
      lo_d = lo_q;
      if (div_done && div_ack) begin
         hi_d = div_rem;
         lo_d = div_quo;
      end
   end

   assign ex_result = id_ex_q.md_op[MD_MFHI] ? hi_q :
                      id_ex_q.md_op[MD_MFLO] ? lo_q : alu_result;

   assign ex_to_mem_bus = {id_ex_q.mem_op, id_ex_q.pc, id_ex_q.data_ram_en, id_ex_q.data_ram_wen,
                           id_ex_q.sel_rf_res, id_ex_q.rf_we, id_ex_q.rf_waddr, ex_result};
   // loads resolve in MEM, so they never forward from here
   assign ex_to_rf_bus  = {id_ex_q.rf_we & ~id_ex_q.sel_rf_res, id_ex_q.rf_waddr, ex_result};

   assign data_sram_en    = id_ex_q.data_ram_en;
   assign data_sram_wen   = id_ex_q.data_ram_wen;
   assign data_sram_addr  = alu_result;
   assign data_sram_wdata = id_ex_q.rdata2;
endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed scenarios with literal results plus
// randomized traffic compared every cycle against an arithmetic reference model.
module tb_ex_stage;
   import ex_stage_pkg::*;

   logic                    clk = 1'b0;
   logic                    rst;
   logic [STALL_WD-1:0]     stall;
   logic [ID_TO_EX_WD-1:0]  id_bus;
   logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
   logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus;
   logic                    data_sram_en;
   logic [3:0]              data_sram_wen;
   logic [31:0]             data_sram_addr, data_sram_wdata;
   logic                    stallreq_for_ex;

   always #5 clk = ~clk;

   ex_stage dut (
      .clk             (clk),
      .rst             (rst),
      .stall           (stall),
      .id_to_ex_bus    (id_bus),
      .ex_to_mem_bus   (ex_to_mem_bus),
      .ex_to_rf_bus    (ex_to_rf_bus),
      .data_sram_en    (data_sram_en),
      .data_sram_wen   (data_sram_wen),
      .data_sram_addr  (data_sram_addr),
      .data_sram_wdata (data_sram_wdata),
      .stallreq_for_ex (stallreq_for_ex)
   );

   int checks = 0;
   int errors = 0;

   // reference model state: the instruction in EX, HI/LO, cycles spent by a divide in EX
   id_to_ex_t   m_reg;
   logic [31:0] m_hi, m_lo;
   int          m_dcnt;

   task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic is_div(input id_to_ex_t r);
      return r.md_op[MD_DIV] | r.md_op[MD_DIVU];
   endfunction

   function automatic logic exp_stallreq();
      return is_div(m_reg) && (m_dcnt < 33);
   endfunction

   function automatic logic [31:0] m_alu(input id_to_ex_t r);
      logic [31:0] a, b;
      a = r.sel_alu_src1[SRC1_RS] ? r.rdata1 : r.sel_alu_src1[SRC1_PC] ? r.pc :
          r.sel_alu_src1[SRC1_SA] ? 32'(r.imm[10:6]) : 32'd0;
      b = r.sel_alu_src2[SRC2_RT] ? r.rdata2 : r.sel_alu_src2[SRC2_SIMM] ? 32'($signed(r.imm)) :
          r.sel_alu_src2[SRC2_8] ? 32'd8 : r.sel_alu_src2[SRC2_ZIMM] ? 32'(r.imm) : 32'd0;
      if (r.alu_op[OP_ADD])  return a + b;
      if (r.alu_op[OP_SUB])  return a - b;
      if (r.alu_op[OP_SLT])  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      if (r.alu_op[OP_SLTU]) return (a < b) ? 32'd1 : 32'd0;
      if (r.alu_op[OP_AND])  return a & b;
      if (r.alu_op[OP_NOR])  return ~(a | b);
      if (r.alu_op[OP_OR])   return a | b;
      if (r.alu_op[OP_XOR])  return a ^ b;
      if (r.alu_op[OP_SLL])  return b << a[4:0];
      if (r.alu_op[OP_SRL])  return b >> a[4:0];
      if (r.alu_op[OP_SRA])  return $signed(b) >>> a[4:0];
      if (r.alu_op[OP_LUI])  return {b[15:0], 16'd0};
      return 32'd0;
   endfunction

   // returns {remainder, quotient}
   function automatic logic [63:0] m_divide(input id_to_ex_t r);
      logic [31:0] a, b, q, rm;
      a = r.rdata1;
      b = r.rdata2;
      if (b == 32'd0) begin
         q = 32'hFFFF_FFFF; rm = a;
      end else if (r.md_op[MD_DIV]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000; rm = 32'd0;
         end else begin
            q = $signed(a) / $signed(b); rm = $signed(a) % $signed(b);
         end
      end else begin
         q = a / b; rm = a % b;
      end
      return {rm, q};
   endfunction

   task automatic compare_all();
      logic [31:0] res;
      res = m_reg.md_op[MD_MFHI] ? m_hi : m_reg.md_op[MD_MFLO] ? m_lo : m_alu(m_reg);
      check("ex_to_mem_bus", 80'(ex_to_mem_bus),
            80'({m_reg.mem_op, m_reg.pc, m_reg.data_ram_en, m_reg.data_ram_wen,
                 m_reg.sel_rf_res, m_reg.rf_we, m_reg.rf_waddr, res}));
      check("ex_to_rf_bus", 80'(ex_to_rf_bus),
            80'({m_reg.rf_we & ~m_reg.sel_rf_res, m_reg.rf_waddr, res}));
      check("sram_en", 80'(data_sram_en), 80'(m_reg.data_ram_en));
      check("sram_wen", 80'(data_sram_wen), 80'(m_reg.data_ram_wen));
      check("sram_addr", 80'(data_sram_addr), 80'(m_alu(m_reg)));
      check("sram_wdata", 80'(data_sram_wdata), 80'(m_reg.rdata2));
      check("stallreq", 80'(stallreq_for_ex), 80'(exp_stallreq()));
   endtask

   // one clock: a divide in EX forces the whole front end to stall
   task automatic cycle(input id_to_ex_t ins, input logic [5:0] want, output logic taken);
      logic [5:0]  st;
      logic [63:0] dr;
      st = exp_stallreq() ? 6'b001111 : want;
      stall  = st;
      id_bus = ins;
      @(posedge clk);
      if (is_div(m_reg) && m_dcnt >= 33 && !st[STALL_EX_MEM]) begin
         dr   = m_divide(m_reg);
         m_hi = dr[63:32];
         m_lo = dr[31:0];
      end
      if (st[STALL_ID_EX] && !st[STALL_EX_MEM]) begin
         m_reg = '0; m_dcnt = 0;
      end else if (!st[STALL_ID_EX]) begin
         m_reg = ins; m_dcnt = 0;
      end else begin
         m_dcnt++;
      end
      taken = !st[STALL_ID_EX];
      @(negedge clk);
      compare_all();
   endtask

   task automatic issue(input id_to_ex_t ins);
      logic taken;
      int   n;
      taken = 1'b0;
      n = 0;
      while (!taken && n < 100) begin
         cycle(ins, 6'b000000, taken);
         n++;
      end
      check("issue_accepted", 80'(taken), 80'(1));
   endtask

   task automatic run_div(input id_to_ex_t next_ins, output int n);
      logic taken;
      n = 0;
      while (stallreq_for_ex === 1'b1 && n < 60) begin
         n++;
         cycle(next_ins, 6'b000000, taken);
      end
   endtask

   function automatic id_to_ex_t mk_addiu(input logic [31:0] rs, input logic [15:0] imm);
      id_to_ex_t r;
      r = '0;
      r.alu_op[OP_ADD] = 1'b1;
      r.sel_alu_src1[SRC1_RS] = 1'b1;
      r.sel_alu_src2[SRC2_SIMM] = 1'b1;
      r.rdata1 = rs; r.imm = imm; r.rf_we = 1'b1; r.rf_waddr = 5'd8; r.pc = 32'h0040_0000;
      return r;
   endfunction

   function automatic id_to_ex_t mk_div(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      id_to_ex_t r;
      r = '0;
      r.md_op[sgn ? MD_DIV : MD_DIVU] = 1'b1;
      r.rdata1 = a; r.rdata2 = b; r.pc = 32'h0000_5000;
      return r;
   endfunction

   function automatic id_to_ex_t mk_mf(input logic hi);
      id_to_ex_t r;
      r = '0;
      r.md_op[hi ? MD_MFHI : MD_MFLO] = 1'b1;
      r.rf_we = 1'b1; r.rf_waddr = 5'd2; r.pc = 32'h0000_5004;
      return r;
   endfunction

   function automatic id_to_ex_t rand_ins();
      id_to_ex_t r;
      int k, m;
      r = '0;
      r.pc = $urandom; r.imm = 16'($urandom); r.rdata1 = $urandom; r.rdata2 = $urandom;
      r.mem_op = 4'($urandom); r.rf_waddr = 5'($urandom); r.rf_we = 1'($urandom);
      r.alu_op = 12'(1 << $urandom_range(0, 11));
      r.sel_alu_src1 = 3'(1 << $urandom_range(0, 2));
      r.sel_alu_src2 = 4'(1 << $urandom_range(0, 3));
      k = $urandom_range(0, 39);
      if (k <= 1) begin
         r.md_op[(k == 0) ? MD_DIV : MD_DIVU] = 1'b1;
         m = $urandom_range(0, 3);
         if (m == 0) r.rdata2 = 32'd0;
         else if (m == 1) begin r.rdata1 = 32'h8000_0000; r.rdata2 = 32'hFFFF_FFFF; end
         else if (m == 2) begin r.rdata1 = 32'($signed(12'($urandom))); r.rdata2 = 32'($signed(5'($urandom))); end
      end else if (k <= 3) r.md_op[MD_MFHI] = 1'b1;
      else if (k <= 5) r.md_op[MD_MFLO] = 1'b1;
      else if (k <= 9) begin
         r.data_ram_en = 1'b1; r.data_ram_wen = 4'($urandom_range(1, 15)); r.rf_we = 1'b0;
      end else if (k <= 13) begin
         r.data_ram_en = 1'b1; r.sel_rf_res = 1'b1; r.rf_we = 1'b1;
      end
      return r;
   endfunction

   initial begin
      id_to_ex_t ins;
      logic      taken;
      int        n, w;

      rst = 1'b1; stall = '0; id_bus = '0;
      m_reg = '0; m_hi = '0; m_lo = '0; m_dcnt = 0;
      repeat (2) @(negedge clk);
      check("reset_mem_bus", 80'(ex_to_mem_bus), 80'(0));
      check("reset_rf_bus", 80'(ex_to_rf_bus), 80'(0));
      check("reset_stallreq", 80'(stallreq_for_ex), 80'(0));
      rst = 1'b0;
      compare_all();

      // addiu 0x10 + sext(0xFFFC)
      issue(mk_addiu(32'h10, 16'hFFFC));
      check("addiu_result", 80'(ex_to_mem_bus[31:0]), 80'(32'hC));
      check("addiu_fwd_we", 80'(ex_to_rf_bus[37]), 80'(1));
      $display("txn addiu result=%h", ex_to_mem_bus[31:0]);

      ins = mk_addiu(32'h1000, 16'd4);
      ins.data_ram_en = 1'b1; ins.data_ram_wen = 4'hF; ins.rf_we = 1'b0; ins.rdata2 = 32'hDEAD_BEEF;
      issue(ins);
      check("store_en", 80'(data_sram_en), 80'(1));
      check("store_wen", 80'(data_sram_wen), 80'(4'hF));
      check("store_addr", 80'(data_sram_addr), 80'(32'h1004));
      check("store_wdata", 80'(data_sram_wdata), 80'(32'hDEAD_BEEF));
      $display("txn store addr=%h wdata=%h", data_sram_addr, data_sram_wdata);
      ins.data_ram_wen = 4'h0; ins.rf_we = 1'b1; ins.sel_rf_res = 1'b1;
      issue(ins);
      check("load_fwd_we", 80'(ex_to_rf_bus[37]), 80'(0));
      check("load_addr", 80'(data_sram_addr), 80'(32'h1004));
      $display("txn load addr=%h", data_sram_addr);

      // div -7 / 2 followed immediately by mflo, mfhi
      issue(mk_div(1'b1, 32'hFFFF_FFF9, 32'd2));
      run_div(mk_mf(1'b0), n);
      check("div_stall_cycles", 80'(n), 80'(33));
      issue(mk_mf(1'b0));
      check("div_lo", 80'(ex_to_rf_bus[31:0]), 80'(32'hFFFF_FFFD));
      issue(mk_mf(1'b1));
      check("div_hi", 80'(ex_to_rf_bus[31:0]), 80'(32'hFFFF_FFFF));
      $display("txn div -7/2 stall=%0d", n);

      issue(mk_div(1'b0, 32'hFFFF_FFFF, 32'd0));
      issue(mk_mf(1'b0));
      check("divz_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFF));
      issue(mk_mf(1'b1));
      check("divz_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFF));
      issue(mk_div(1'b0, 32'd100, 32'd7));
      issue(mk_mf(1'b0));
      check("divu_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'd14));
      issue(mk_mf(1'b1));
      check("divu_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'd2));
      $display("txn divu checks done");

      // bubble insertion
      issue(mk_addiu(32'h55, 16'h1));
      cycle(mk_addiu(32'h77, 16'h2), 6'b000111, taken);
      check("bubble_mem_bus", 80'(ex_to_mem_bus), 80'(0));
      check("bubble_rf_bus", 80'(ex_to_rf_bus), 80'(0));
      check("bubble_addr", 80'(data_sram_addr), 80'(0));
      $display("txn bubble");

      // EX/MEM held while the divider sits in DONE
      issue(mk_div(1'b0, 32'd50, 32'd8));
      run_div(mk_mf(1'b0), n);
      repeat (3) begin
         cycle(mk_mf(1'b0), 6'b001111, taken);
         check("done_hold_stallreq", 80'(stallreq_for_ex), 80'(0));
         check("done_hold_pc", 80'(ex_to_mem_bus[75:44]), 80'(32'h0000_5000));
      end
      issue(mk_mf(1'b0));
      check("held_div_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'd6));
      issue(mk_mf(1'b1));
      check("held_div_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'd2));
      $display("txn held divu 50/8");

      // asynchronous reset in the middle of a divide
      issue(mk_div(1'b1, 32'hFFFF_FF9C, 32'd7));
      repeat (10) cycle(mk_mf(1'b1), 6'b000000, taken);
      #2 rst = 1'b1;
      #1;
      check("async_rst_stallreq", 80'(stallreq_for_ex), 80'(0));
      check("async_rst_mem_bus", 80'(ex_to_mem_bus), 80'(0));
      m_reg = '0; m_hi = '0; m_lo = '0; m_dcnt = 0;
      @(negedge clk);
      rst = 1'b0;
      compare_all();
      issue(mk_mf(1'b1));
      check("rst_hi_zero", 80'(ex_to_mem_bus[31:0]), 80'(0));
      issue(mk_mf(1'b0));
      check("rst_lo_zero", 80'(ex_to_mem_bus[31:0]), 80'(0));
      issue(mk_div(1'b1, 32'hFFFF_FF9C, 32'd7));
      issue(mk_mf(1'b0));
      check("post_rst_lo", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFF2));
      issue(mk_mf(1'b1));
      check("post_rst_hi", 80'(ex_to_mem_bus[31:0]), 80'(32'hFFFF_FFFE));
      $display("txn reset during RUN");

      for (int i = 0; i < 3000; i++) begin
         w = $urandom_range(0, 9);
         cycle(rand_ins(), (w < 7) ? 6'b000000 : (w < 8) ? 6'b000111 : 6'b001111, taken);
      end
      $display("txn random traffic 3000 cycles");

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
